// File: rtl/lfsr_pattern_gen_if.sv
// Pattern stream from the LFSR generator to the fault injector (valid/ready).
interface lfsr_pattern_gen_if #(
    parameter int unsigned N_BITS = 8
);
    logic              out_valid_o;
    logic              out_ready_i;
    logic [N_BITS-1:0] out_data_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        output out_ready_i
    );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// Seeded Fibonacci/Galois LFSR emitting a programmed number of fault addresses
// over a valid/ready stream, with zero-seed substitution and lockup recovery.
module lfsr_pattern_gen #(
    parameter int unsigned       N_BITS = 8,
    parameter logic [N_BITS-1:0] TAPS   = N_BITS'(8'hB8),
    parameter int unsigned       CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [N_BITS-1:0]   seed_i,
    input  logic [CNT_W-1:0]    num_steps_i,
    input  logic                abort_i,
    lfsr_pattern_gen_if.master  out_if,
    output logic                busy_o,
    output logic                done_o,
    output logic                zero_seed_o,
    output logic                lockup_o,
    output logic [CNT_W-1:0]    emitted_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] lfsr_q, lfsr_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  steps_q, steps_d;
    logic [CNT_W-1:0]  emitted_q, emitted_d;
    logic              zero_q, zero_d;
    logic              lock_q, lock_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fib_fb;
    logic [N_BITS-1:0] fib_next, gal_next, step_next, adv_next;
    logic              step_is_zero;
    logic              xfer;

    // Next LFSR value for the selected mode, with the all-zero state forced to 1.
    always_comb begin
        fib_fb       = ^(lfsr_q & TAPS);
        fib_next     = {fib_fb, lfsr_q[N_BITS-1:1]};
        gal_next     = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        step_next    = mode_q ? gal_next : fib_next;
        step_is_zero = (step_next == '0);
        adv_next     = step_is_zero ? N_BITS'(1) : step_next;
    end

    assign xfer = valid_q & out_if.out_ready_i;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        mode_d    = mode_q;
        steps_d   = steps_q;
        emitted_d = emitted_q;
        zero_d    = zero_q;
        lock_d    = lock_q;

        case (state_q)
            S_IDLE: begin
                // abort_i takes priority over a simultaneous start request
                if (start_i && !abort_i) begin
                    mode_d    = mode_i;
                    steps_d   = num_steps_i;
                    emitted_d = '0;
                    zero_d    = (seed_i == '0);
                    lock_d    = 1'b0;
                    lfsr_d    = (seed_i == '0) ? N_BITS'(1) : seed_i;
                    state_d   = (num_steps_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    lfsr_d    = adv_next;
                    lock_d    = lock_q | step_is_zero;
                    emitted_d = emitted_q + CNT_W'(1);
                    if (emitted_q == steps_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            lfsr_q    <= '0;
            mode_q    <= 1'b0;
            steps_q   <= '0;
            emitted_q <= '0;
            zero_q    <= 1'b0;
            lock_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            mode_q    <= mode_d;
            steps_q   <= steps_d;
            emitted_q <= emitted_d;
            zero_q    <= zero_d;
            lock_q    <= lock_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out_if.out_valid_o = valid_q;
    assign out_if.out_data_o  = lfsr_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign zero_seed_o        = zero_q;
    assign lockup_o           = lock_q;
    assign emitted_o          = emitted_q;

endmodule
